// File: rtl/datapath_seq_ctrl_if.sv
// Fetch-side instruction handshake for the datapath sequencer.
// The fetch unit is the master (offers instructions), the sequencer the slave.
interface datapath_seq_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface : datapath_seq_ctrl_if

// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle sequencer for the register-file/ALU datapath.
// Takes one RV32I instruction per valid/ready transaction, decodes R-type ALU
// ops and BEQ/BNE, and steps the datapath through DECODE -> EXEC -> WB.
// Every output is a flop: nothing combinational reaches the ports from the
// instruction handshake inputs.
module datapath_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,            // asynchronous, active-low
  datapath_seq_ctrl_if.slave   fetch,
  input  logic                 zero_flag,
  output logic [4:0]           mem_read_addr_1,
  output logic [4:0]           mem_read_addr_2,
  output logic [4:0]           mem_write_addr,
  output logic [3:0]           alu_ctrl,
  output logic                 r_or_w,
  output logic                 done,
  output logic                 branch_taken,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired_cnt
);

  localparam logic [6:0]       OP_RTYPE  = 7'b0110011;
  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       F7_BASE   = 7'b0000000;
  localparam logic [6:0]       F7_ALT    = 7'b0100000;
  localparam logic [2:0]       F3_ADDSUB = 3'b000;
  localparam logic [2:0]       F3_SRLSRA = 3'b101;
  localparam logic [2:0]       F3_BEQ    = 3'b000;
  localparam logic [2:0]       F3_BNE    = 3'b001;
  localparam logic [3:0]       ALU_SUB   = 4'b1000;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  // Only the instruction fields still needed after the accept edge are kept;
  // register addresses and the ALU select are captured into their output
  // flops directly at accept so they are already valid in DECODE.
  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } ir_t;

  state_t           state_q,  state_d;
  ir_t              ir_q,     ir_d;
  logic             ready_q,  ready_d;
  logic [4:0]       rs1_q,    rs1_d;
  logic [4:0]       rs2_q,    rs2_d;
  logic [4:0]       rd_q,     rd_d;
  logic [3:0]       alu_q,    alu_d;
  logic             wr_q,     wr_d;
  logic             done_q,   done_d;
  logic             taken_q,  taken_d;
  logic             ill_q,    ill_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             accept;
  logic             ir_legal;
  logic [6:0]       in_opcode;

  // Supported-instruction check on the latched instruction fields.
  function automatic logic is_legal(input ir_t ir);
    logic ok;
    ok = 1'b0;
    if (ir.opcode == OP_RTYPE) begin
      ok = (ir.funct7 == F7_BASE) ||
           ((ir.funct7 == F7_ALT) &&
            ((ir.funct3 == F3_ADDSUB) || (ir.funct3 == F3_SRLSRA)));
    end else if (ir.opcode == OP_BRANCH) begin
      ok = (ir.funct3 == F3_BEQ) || (ir.funct3 == F3_BNE);
    end
    return ok;
  endfunction

  assign accept    = fetch.instr_valid && ready_q;
  assign in_opcode = fetch.instr[6:0];
  assign ir_legal  = is_legal(ir_q);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    ir_d    = ir_q;
    ready_d = ready_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    taken_d = 1'b0;
    ill_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ir_d    = '{funct7: fetch.instr[31:25],
                      funct3: fetch.instr[14:12],
                      rd:     fetch.instr[11:7],
                      opcode: in_opcode};
          ready_d = 1'b0;
          rs1_d   = fetch.instr[19:15];
          rs2_d   = fetch.instr[24:20];
          // Branches never name a destination register.
          rd_d    = (in_opcode == OP_RTYPE) ? fetch.instr[11:7] : 5'd0;
          if (in_opcode == OP_RTYPE) begin
            alu_d = {fetch.instr[30], fetch.instr[14:12]};
          end else if (in_opcode == OP_BRANCH) begin
            alu_d = ALU_SUB;
          end else begin
            alu_d = 4'd0;
          end
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (ir_legal) begin
          state_d = S_EXEC;
        end else begin
          // Reject: one-cycle illegal pulse, datapath controls back to idle.
          ill_d   = 1'b1;
          ready_d = 1'b1;
          rs1_d   = 5'd0;
          rs2_d   = 5'd0;
          rd_d    = 5'd0;
          alu_d   = 4'd0;
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        // The ALU has settled by the end of EXEC; zero_flag is captured here
        // straight into the branch outcome flop shown during WB.
        done_d  = 1'b1;
        wr_d    = (ir_q.opcode == OP_RTYPE) && (ir_q.rd != 5'd0);
        if (ir_q.opcode == OP_BRANCH) begin
          taken_d = (ir_q.funct3 == F3_BNE) ? !zero_flag : zero_flag;
        end
        state_d = S_WB;
      end

      S_WB: begin
        cnt_d   = cnt_q + CNT_ONE;    // wraps silently at 2^CNT_W
        ready_d = 1'b1;
        rs1_d   = 5'd0;
        rs2_d   = 5'd0;
        rd_d    = 5'd0;
        alu_d   = 4'd0;
        state_d = S_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      ready_q <= 1'b1;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      alu_q   <= 4'd0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle regardless of statement order.
      state_q <= state_d;
      ir_q    <= ir_d;
      ready_q <= ready_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch.instr_ready = ready_q;
  assign mem_read_addr_1   = rs1_q;
  assign mem_read_addr_2   = rs2_q;
  assign mem_write_addr    = rd_q;
  assign alu_ctrl          = alu_q;
  assign r_or_w            = wr_q;
  assign done              = done_q;
  assign branch_taken      = taken_q;
  assign illegal           = ill_q;
  assign retired_cnt       = cnt_q;

endmodule : datapath_seq_ctrl

// File: tb/tb_datapath_seq_ctrl.sv
// Self-checking bench for datapath_seq_ctrl. Expected behaviour comes from a
// per-instruction model derived from the RV32I field rules; a second instance
// with a 3-bit retired counter exercises the counter wrap in few cycles.
module tb_datapath_seq_ctrl;

  logic clk;
  logic reset;
  logic zero_flag;

  datapath_seq_ctrl_if d_if ();
  datapath_seq_ctrl_if w_if ();

  logic [4:0]  a1, a2, wa;
  logic [3:0]  alu;
  logic        wr, dn, tk, ill;
  logic [15:0] cnt;

  logic [4:0]  w_a1, w_a2, w_wa;
  logic [3:0]  w_alu;
  logic        w_wr, w_dn, w_tk, w_ill;
  logic [2:0]  w_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;
  int cycle = 0;
  int acc_cycle = 0;

  typedef struct {
    bit         legal;
    bit         is_br;
    bit         bne;
    bit         wr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu;
  } exp_t;

  datapath_seq_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .fetch(d_if.slave), .zero_flag(zero_flag),
    .mem_read_addr_1(a1), .mem_read_addr_2(a2), .mem_write_addr(wa),
    .alu_ctrl(alu), .r_or_w(wr), .done(dn), .branch_taken(tk),
    .illegal(ill), .retired_cnt(cnt)
  );

  datapath_seq_ctrl #(.CNT_W(3)) u_dut_w (
    .clk(clk), .reset(reset), .fetch(w_if.slave), .zero_flag(zero_flag),
    .mem_read_addr_1(w_a1), .mem_read_addr_2(w_a2), .mem_write_addr(w_wa),
    .alu_ctrl(w_alu), .r_or_w(w_wr), .done(w_dn), .branch_taken(w_tk),
    .illegal(w_ill), .retired_cnt(w_cnt)
  );

  assign w_if.instr       = d_if.instr;
  assign w_if.instr_valid = d_if.instr_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference decode: what the datapath should see for one instruction.
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = i[6:0];
    f7 = i[31:25];
    f3 = i[14:12];
    e = '{default: 0};
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    if (op == 7'h33) begin
      e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.alu   = {i[30], f3};
      e.rd    = i[11:7];
      e.wr    = (i[11:7] != 5'd0);
    end else if (op == 7'h63) begin
      e.legal = (f3 == 3'd0) || (f3 == 3'd1);
      e.is_br = 1'b1;
      e.bne   = (f3 == 3'd1);
      e.alu   = 4'b1000;
    end
    return e;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    d_if.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_cnt = 0;
    @(negedge clk);
  endtask

  // Run one instruction from a negedge; returns at the negedge of the IDLE
  // cycle that follows. With hold=1 valid stays high carrying nxt while busy.
  task automatic do_instr(input logic [31:0] i, input bit zf, input bit hold,
                          input logic [31:0] nxt, input string tag);
    exp_t e;
    bit   exp_tk;
    int   k;
    e = model(i);
    exp_tk = e.is_br && (e.bne ? !zf : zf);
    d_if.instr = i;
    d_if.instr_valid = 1'b1;
    zero_flag = 1'($urandom);
    k = 0;
    while (d_if.instr_ready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (d_if.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: got %b need 1", tag, d_if.instr_ready);
      d_if.instr_valid = 1'b0;
      return;
    end
    acc_cycle = cycle;
    @(negedge clk);  // DECODE
    d_if.instr_valid = hold;
    d_if.instr = hold ? nxt : $urandom;
    zero_flag = !zf;
    n_tests++;
    if (d_if.instr_ready !== 1'b0 || dn !== 1'b0 || wr !== 1'b0 || ill !== 1'b0) begin
      n_fail++;
      $display("FAIL %s decode_ctl: got rdy/done/wr/ill=%b%b%b%b need 0000", tag,
               d_if.instr_ready, dn, wr, ill);
    end
    if (e.legal) begin
      n_tests++;
      if ({a1, a2, wa, alu} !== {e.rs1, e.rs2, e.rd, e.alu}) begin
        n_fail++;
        $display("FAIL %s decode_fields: got a1=%0d a2=%0d wa=%0d alu=%b need %0d %0d %0d %b",
                 tag, a1, a2, wa, alu, e.rs1, e.rs2, e.rd, e.alu);
      end
    end
    @(negedge clk);
    if (!e.legal) begin
      n_tests++;
      if (ill !== 1'b1 || dn !== 1'b0 || wr !== 1'b0 || d_if.instr_ready !== 1'b1
          || alu !== 4'd0 || cnt !== 16'(model_cnt)) begin
        n_fail++;
        $display("FAIL %s illegal_pulse: got ill=%b done=%b wr=%b rdy=%b alu=%b cnt=%0d need 1 0 0 1 0000 %0d",
                 tag, ill, dn, wr, d_if.instr_ready, alu, cnt, 16'(model_cnt));
      end
      return;
    end
    // EXEC: the flag value presented here is the one that must be used.
    zero_flag = zf;
    n_tests++;
    if ({a1, a2, wa, alu} !== {e.rs1, e.rs2, e.rd, e.alu} || dn !== 1'b0 || wr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s exec: got a1=%0d a2=%0d wa=%0d alu=%b done=%b wr=%b need %0d %0d %0d %b 0 0",
               tag, a1, a2, wa, alu, dn, wr, e.rs1, e.rs2, e.rd, e.alu);
    end
    @(negedge clk);  // WB
    zero_flag = !zf;
    n_tests++;
    if ({a1, a2, wa, alu} !== {e.rs1, e.rs2, e.rd, e.alu}) begin
      n_fail++;
      $display("FAIL %s wb_fields: got a1=%0d a2=%0d wa=%0d alu=%b need %0d %0d %0d %b",
               tag, a1, a2, wa, alu, e.rs1, e.rs2, e.rd, e.alu);
    end
    n_tests++;
    if (dn !== 1'b1 || wr !== e.wr || tk !== exp_tk || ill !== 1'b0 || cnt !== 16'(model_cnt)) begin
      n_fail++;
      $display("FAIL %s wb_ctl: got done=%b wr=%b taken=%b ill=%b cnt=%0d need 1 %b %b 0 %0d",
               tag, dn, wr, tk, ill, cnt, e.wr, exp_tk, 16'(model_cnt));
    end
    model_cnt++;
    @(negedge clk);  // IDLE again
    n_tests++;
    if (dn !== 1'b0 || wr !== 1'b0 || d_if.instr_ready !== 1'b1 || alu !== 4'd0
        || cnt !== 16'(model_cnt) || w_cnt !== 3'(model_cnt)) begin
      n_fail++;
      $display("FAIL %s idle_after: got done=%b wr=%b rdy=%b alu=%b cnt=%0d cnt3=%0d need 0 0 1 0000 %0d %0d",
               tag, dn, wr, d_if.instr_ready, alu, cnt, w_cnt, 16'(model_cnt), 3'(model_cnt));
    end
    if (!hold) d_if.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (d_if.instr_ready !== 1'b1 || cnt !== 16'd0 || dn !== 1'b0 || wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy=%b cnt=%0d done=%b wr=%b need 1 0 0 0",
               d_if.instr_ready, cnt, dn, wr);
    end
    // Start an ADD, then pull reset during its EXEC cycle.
    d_if.instr = 32'h004A02B3;
    d_if.instr_valid = 1'b1;
    @(negedge clk);              // DECODE
    d_if.instr_valid = 1'b0;
    @(negedge clk);              // EXEC
    reset = 1'b0;
    #1;
    n_tests++;
    if ({a1, a2, wa, alu, wr, dn, tk, ill} !== 23'd0 || cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_async: got a1=%0d a2=%0d wa=%0d alu=%b wr=%b done=%b tk=%b ill=%b cnt=%0d need all 0",
               a1, a2, wa, alu, wr, dn, tk, ill, cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (d_if.instr_ready !== 1'b1 || cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b cnt=%0d need 1 0", d_if.instr_ready, cnt);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (wr !== 1'b0 || dn !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_abort: cycle %0d got wr=%b done=%b need 0 0", c, wr, dn);
      end
    end
    model_cnt = 0;
  endtask

  task automatic test_add();
    do_instr(32'h004A02B3, 1'b0, 1'b0, 32'h0, "add_x5_x20_x4");
  endtask

  task automatic test_sub_x0();
    do_instr(32'h40108033, 1'b1, 1'b0, 32'h0, "sub_x0");
  endtask

  task automatic test_branch();
    do_instr(32'h00208063, 1'b1, 1'b0, 32'h0, "beq_z1");
    do_instr(32'h00209063, 1'b1, 1'b0, 32'h0, "bne_z1");
    do_instr(32'h00208063, 1'b0, 1'b0, 32'h0, "beq_z0");
    do_instr(32'h00209063, 1'b0, 1'b0, 32'h0, "bne_z0");
  endtask

  task automatic test_illegal();
    do_instr(32'h00000013, 1'b0, 1'b0, 32'h0, "ill_addi");
    @(negedge clk);
    n_tests++;
    if (ill !== 1'b0 || d_if.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_one_cycle: got ill=%b rdy=%b need 0 1", ill, d_if.instr_ready);
    end
    do_instr(32'h02000033, 1'b0, 1'b0, 32'h0, "ill_mul");
    do_instr(32'h40001033, 1'b0, 1'b0, 32'h0, "ill_alt_sll");
    do_instr(32'h00004063, 1'b0, 1'b0, 32'h0, "ill_blt");
    do_instr(32'h00418133, 1'b0, 1'b0, 32'h0, "add_after_ill");
  endtask

  task automatic test_back_to_back();
    logic [31:0] adds [3];
    int prev;
    adds[0] = 32'h002081B3;   // add x3,x1,x2
    adds[1] = 32'h00520233;   // add x4,x4,x5
    adds[2] = 32'h007302B3;   // add x5,x6,x7
    prev = -1;
    for (int n = 0; n < 3; n++) begin
      do_instr(adds[n], 1'b0, (n < 2), (n < 2) ? adds[n+1] : 32'h0, "b2b_add");
      if (prev >= 0) begin
        n_tests++;
        if (acc_cycle - prev !== 4) begin
          n_fail++;
          $display("FAIL b2b_spacing: got %0d cycles need 4", acc_cycle - prev);
        end
      end
      prev = acc_cycle;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int n = 0; n < 9; n++)
      do_instr(32'h00A5C533, 1'(n), (n < 8), 32'h00A5C533, "wrap_xor");
    n_tests++;
    if (w_cnt !== 3'd1 || cnt !== 16'd9) begin
      n_fail++;
      $display("FAIL wrap_count: got cnt3=%0d cnt16=%0d need 1 9", w_cnt, cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] cur, nxt, r;
    bit h;
    r = $urandom;
    cur = r;
    for (int n = 0; n < 60; n++) begin
      int k;
      r = $urandom;
      k = $urandom_range(0, 9);
      if (k < 5) begin
        r[6:0] = 7'h33;
        if (k != 4) r[31:25] = r[25] ? 7'h20 : 7'h00;
      end else if (k < 8) begin
        r[6:0] = 7'h63;
        if (k < 7) r[14:13] = 2'b00;
      end
      nxt = r;
      h = 1'($urandom);
      do_instr(cur, 1'($urandom), h, nxt, "rand");
      cur = nxt;
    end
    d_if.instr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    zero_flag = 1'b0;
    d_if.instr = 32'h0;
    d_if.instr_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_x0();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_datapath_seq_ctrl
